chopper_sequencer: RTL and testbench

CHOPPER_SEQUENCER -- requirements
Module: chopper_sequencer

---
 rtl/chopper_sequencer.sv | 153 +++++++++++++++
 tb/tb_chopper_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/chopper_sequencer.sv
// Two-channel chopper timing sequencer: IDLE -> BLANK -> ON -> OFF -> BLANK cycle per
// channel, with blank / off / minimum-on countdowns and saturating off-event counters.
module chopper_sequencer #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic [7:0]             config_blanktime,
  input  logic [9:0]             config_offtime,
  input  logic [7:0]             config_minimum_on_time,
  input  logic                   offtimer_en0,
  input  logic                   offtimer_en1,
  input  logic [7:0]             phase_ct,
  output logic [7:0]             blank_timer0,
  output logic [7:0]             blank_timer1,
  output logic [9:0]             off_timer0,
  output logic [9:0]             off_timer1,
  output logic [7:0]             minimum_on_timer0,
  output logic [7:0]             minimum_on_timer1,
  output logic [1:0]             state0,
  output logic [1:0]             state1,
  output logic [COUNT_WIDTH-1:0] off_count0,
  output logic [COUNT_WIDTH-1:0] off_count1
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;
  localparam logic [1:0] ST_OFF   = 2'd3;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic [7:0] phase_prev_reg;
  logic       step_event;

  // Reset also loads the live phase, so leaving reset never looks like a step.
  always_ff @(posedge clk) begin
    phase_prev_reg <= phase_ct;
  end

  assign step_event = (phase_ct != phase_prev_reg);

  logic                   offtimer_en_ch [2];
  logic [1:0]             state_out      [2];
  logic [7:0]             blank_out      [2];
  logic [9:0]             off_out        [2];
  logic [7:0]             min_on_out     [2];
  logic [COUNT_WIDTH-1:0] count_out      [2];

  assign offtimer_en_ch[0] = offtimer_en0;
  assign offtimer_en_ch[1] = offtimer_en1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_channel
      logic [1:0]             state_reg, state_next;
      logic [7:0]             blank_reg, blank_next;
      logic [9:0]             off_reg, off_next;
      logic [7:0]             min_on_reg, min_on_next;
      logic [COUNT_WIDTH-1:0] count_reg, count_next;

      always_comb begin
        state_next  = state_reg;
        blank_next  = (blank_reg != 8'd0) ? blank_reg - 8'd1 : 8'd0;
        min_on_next = (min_on_reg != 8'd0) ? min_on_reg - 8'd1 : 8'd0;
        off_next    = off_reg;
        count_next  = count_reg;
        case (state_reg)
          ST_IDLE: begin
            state_next  = ST_BLANK;
            blank_next  = config_blanktime;
            min_on_next = config_minimum_on_time;
            off_next    = 10'd0;
          end
          ST_BLANK: begin
            if (step_event) begin
              blank_next  = config_blanktime;
              min_on_next = config_minimum_on_time;
            end else if (blank_reg <= 8'd1) begin
              state_next = ST_ON;
            end
          end
          ST_ON: begin
            blank_next = 8'd0;
            off_next   = 10'd0;
            // An off request wins over a simultaneous step event.
            if (offtimer_en_ch[gi]) begin
              state_next = ST_OFF;
              off_next   = config_offtime;
              if (count_reg != COUNT_MAX) begin
                count_next = count_reg + 1'b1;
              end
            end else if (step_event) begin
              state_next  = ST_BLANK;
              blank_next  = config_blanktime;
              min_on_next = config_minimum_on_time;
            end
          end
          default: begin
            if (off_reg <= 10'd1) begin
              state_next  = ST_BLANK;
              off_next    = 10'd0;
              blank_next  = config_blanktime;
              min_on_next = config_minimum_on_time;
            end else begin
              off_next = off_reg - 10'd1;
            end
          end
        endcase
        if (!enable) begin
          state_next  = ST_IDLE;
          blank_next  = 8'd0;
          off_next    = 10'd0;
          min_on_next = 8'd0;
        end
      end

      always_ff @(posedge clk) begin
        if (!resetn) begin
          state_reg  <= ST_IDLE;
          blank_reg  <= 8'd0;
          off_reg    <= 10'd0;
          min_on_reg <= 8'd0;
          count_reg  <= '0;
        end else begin
          state_reg  <= state_next;
          blank_reg  <= blank_next;
          off_reg    <= off_next;
          min_on_reg <= min_on_next;
          count_reg  <= count_next;
        end
      end

      assign state_out[gi]  = state_reg;
      assign blank_out[gi]  = blank_reg;
      assign off_out[gi]    = off_reg;
      assign min_on_out[gi] = min_on_reg;
      assign count_out[gi]  = count_reg;
    end
  endgenerate

  assign state0            = state_out[0];
  assign state1            = state_out[1];
  assign blank_timer0      = blank_out[0];
  assign blank_timer1      = blank_out[1];
  assign off_timer0        = off_out[0];
  assign off_timer1        = off_out[1];
  assign minimum_on_timer0 = min_on_out[0];
  assign minimum_on_timer1 = min_on_out[1];
  assign off_count0        = count_out[0];
  assign off_count1        = count_out[1];

endmodule

// File: tb/tb_chopper_sequencer.sv
// Directed bench for chopper_sequencer: vector table for the main cycle plus
// hand-written sequences for zero configs, enable drop, reset and counter saturation.
module tb_chopper_sequencer;

  logic       clk = 1'b0;
  logic       resetn, enable, offtimer_en0, offtimer_en1;
  logic [7:0] config_blanktime, config_minimum_on_time, phase_ct;
  logic [9:0] config_offtime;

  logic [7:0]  blank_timer0, blank_timer1, minimum_on_timer0, minimum_on_timer1;
  logic [9:0]  off_timer0, off_timer1;
  logic [1:0]  state0, state1;
  logic [15:0] off_count0, off_count1;

  logic [7:0]  s_bt0, s_bt1, s_mt0, s_mt1;
  logic [9:0]  s_ot0, s_ot1;
  logic [1:0]  s_st0, s_st1;
  logic [3:0]  s_cnt0, s_cnt1;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  chopper_sequencer dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .config_blanktime(config_blanktime), .config_offtime(config_offtime),
    .config_minimum_on_time(config_minimum_on_time),
    .offtimer_en0(offtimer_en0), .offtimer_en1(offtimer_en1), .phase_ct(phase_ct),
    .blank_timer0(blank_timer0), .blank_timer1(blank_timer1),
    .off_timer0(off_timer0), .off_timer1(off_timer1),
    .minimum_on_timer0(minimum_on_timer0), .minimum_on_timer1(minimum_on_timer1),
    .state0(state0), .state1(state1),
    .off_count0(off_count0), .off_count1(off_count1)
  );

  chopper_sequencer #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .resetn(resetn), .enable(enable),
    .config_blanktime(config_blanktime), .config_offtime(config_offtime),
    .config_minimum_on_time(config_minimum_on_time),
    .offtimer_en0(offtimer_en0), .offtimer_en1(offtimer_en1), .phase_ct(phase_ct),
    .blank_timer0(s_bt0), .blank_timer1(s_bt1),
    .off_timer0(s_ot0), .off_timer1(s_ot1),
    .minimum_on_timer0(s_mt0), .minimum_on_timer1(s_mt1),
    .state0(s_st0), .state1(s_st1),
    .off_count0(s_cnt0), .off_count1(s_cnt1)
  );

  typedef struct {
    int en, oe0, oe1, ph, bl, mo, of;
    int s0, bt0, ot0, mt0;
    int s1, bt1, ot1, mt1;
    int c0, c1;
  } vec_t;

  vec_t vecs [23];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_ch0(input string nm, input int s, input int bt, input int ot, input int mt);
    chk({nm, " state0"}, int'(state0), s);
    chk({nm, " blank0"}, int'(blank_timer0), bt);
    chk({nm, " off0"}, int'(off_timer0), ot);
    chk({nm, " minon0"}, int'(minimum_on_timer0), mt);
  endtask

  task automatic chk_ch1(input string nm, input int s, input int bt, input int ot, input int mt);
    chk({nm, " state1"}, int'(state1), s);
    chk({nm, " blank1"}, int'(blank_timer1), bt);
    chk({nm, " off1"}, int'(off_timer1), ot);
    chk({nm, " minon1"}, int'(minimum_on_timer1), mt);
  endtask

  task automatic set_cfg(input int bl, input int mo, input int of);
    config_blanktime       = 8'(bl);
    config_minimum_on_time = 8'(mo);
    config_offtime         = 10'(of);
  endtask

  initial begin
    //           en oe0 oe1 ph  bl mo of | s0 bt0 ot0 mt0 | s1 bt1 ot1 mt1 | c0 c1
    vecs[0]  = '{0, 0, 0, 16, 3, 5, 4,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0};
    vecs[1]  = '{1, 0, 0, 16, 3, 5, 4,  1, 3, 0, 5,  1, 3, 0, 5,  0, 0};
    vecs[2]  = '{1, 0, 0, 16, 3, 5, 4,  1, 2, 0, 4,  1, 2, 0, 4,  0, 0};
    vecs[3]  = '{1, 0, 0, 16, 3, 5, 4,  1, 1, 0, 3,  1, 1, 0, 3,  0, 0};
    vecs[4]  = '{1, 0, 0, 16, 3, 5, 4,  2, 0, 0, 2,  2, 0, 0, 2,  0, 0};
    vecs[5]  = '{1, 0, 0, 16, 3, 5, 4,  2, 0, 0, 1,  2, 0, 0, 1,  0, 0};
    vecs[6]  = '{1, 1, 0, 16, 3, 5, 4,  3, 0, 4, 0,  2, 0, 0, 0,  1, 0};
    vecs[7]  = '{1, 0, 0, 16, 3, 5, 4,  3, 0, 3, 0,  2, 0, 0, 0,  1, 0};
    vecs[8]  = '{1, 0, 0, 16, 3, 5, 9,  3, 0, 2, 0,  2, 0, 0, 0,  1, 0};
    vecs[9]  = '{1, 0, 0, 16, 3, 5, 9,  3, 0, 1, 0,  2, 0, 0, 0,  1, 0};
    vecs[10] = '{1, 0, 0, 16, 3, 5, 9,  1, 3, 0, 5,  2, 0, 0, 0,  1, 0};
    vecs[11] = '{1, 1, 1, 16, 3, 5, 9,  1, 2, 0, 4,  3, 0, 9, 0,  1, 1};
    vecs[12] = '{1, 0, 0, 17, 3, 5, 9,  1, 3, 0, 5,  3, 0, 8, 0,  1, 1};
    vecs[13] = '{1, 0, 1, 17, 3, 5, 9,  1, 2, 0, 4,  3, 0, 7, 0,  1, 1};
    vecs[14] = '{1, 0, 0, 17, 3, 5, 9,  1, 1, 0, 3,  3, 0, 6, 0,  1, 1};
    vecs[15] = '{1, 0, 0, 17, 3, 5, 9,  2, 0, 0, 2,  3, 0, 5, 0,  1, 1};
    vecs[16] = '{1, 0, 0, 17, 3, 5, 9,  2, 0, 0, 1,  3, 0, 4, 0,  1, 1};
    vecs[17] = '{1, 1, 0, 18, 3, 5, 9,  3, 0, 9, 0,  3, 0, 3, 0,  2, 1};
    vecs[18] = '{1, 0, 0, 18, 3, 5, 9,  3, 0, 8, 0,  3, 0, 2, 0,  2, 1};
    vecs[19] = '{1, 0, 0, 18, 3, 5, 9,  3, 0, 7, 0,  3, 0, 1, 0,  2, 1};
    vecs[20] = '{1, 0, 0, 18, 3, 5, 9,  3, 0, 6, 0,  1, 3, 0, 5,  2, 1};
    vecs[21] = '{1, 0, 0, 18, 3, 5, 9,  3, 0, 5, 0,  1, 2, 0, 4,  2, 1};
    vecs[22] = '{0, 0, 0, 18, 3, 5, 9,  0, 0, 0, 0,  0, 0, 0, 0,  2, 1};

    resetn = 1'b0; enable = 1'b0; offtimer_en0 = 1'b0; offtimer_en1 = 1'b0;
    phase_ct = 8'h10;
    set_cfg(3, 5, 4);
    tick();
    tick();
    $display("reset: state0=%0d state1=%0d cnt0=%0d", state0, state1, off_count0);
    chk_ch0("reset", 0, 0, 0, 0);
    chk_ch1("reset", 0, 0, 0, 0);
    chk("reset cnt0", int'(off_count0), 0);
    chk("reset cnt1", int'(off_count1), 0);
    resetn = 1'b1;

    for (int i = 0; i < 23; i++) begin
      enable       = 1'(vecs[i].en);
      offtimer_en0 = 1'(vecs[i].oe0);
      offtimer_en1 = 1'(vecs[i].oe1);
      phase_ct     = 8'(vecs[i].ph);
      set_cfg(vecs[i].bl, vecs[i].mo, vecs[i].of);
      tick();
      $display("vec %0d: s0=%0d bt0=%0d ot0=%0d mt0=%0d s1=%0d bt1=%0d ot1=%0d mt1=%0d c0=%0d c1=%0d",
               i, state0, blank_timer0, off_timer0, minimum_on_timer0,
               state1, blank_timer1, off_timer1, minimum_on_timer1, off_count0, off_count1);
      chk_ch0($sformatf("vec%0d", i), vecs[i].s0, vecs[i].bt0, vecs[i].ot0, vecs[i].mt0);
      chk_ch1($sformatf("vec%0d", i), vecs[i].s1, vecs[i].bt1, vecs[i].ot1, vecs[i].mt1);
      chk($sformatf("vec%0d cnt0", i), int'(off_count0), vecs[i].c0);
      chk($sformatf("vec%0d cnt1", i), int'(off_count1), vecs[i].c1);
    end
    offtimer_en0 = 1'b0; offtimer_en1 = 1'b0;

    // Step on ch0 and off request on ch1 at the same edge, then enable drop mid-OFF.
    set_cfg(3, 5, 200);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk_ch0("seqA on", 2, 0, 0, 2);
    phase_ct = 8'h13; offtimer_en1 = 1'b1;
    tick();
    $display("seqA step+req: s0=%0d bt0=%0d s1=%0d ot1=%0d c1=%0d", state0, blank_timer0, state1, off_timer1, off_count1);
    chk_ch0("seqA step", 1, 3, 0, 5);
    chk_ch1("seqA req", 3, 0, 200, 1);
    chk("seqA cnt1", int'(off_count1), 2);
    offtimer_en1 = 1'b0; enable = 1'b0;
    tick();
    $display("seqA disable: s1=%0d ot1=%0d c1=%0d", state1, off_timer1, off_count1);
    chk_ch1("seqA dis", 0, 0, 0, 0);
    chk("seqA dis cnt1", int'(off_count1), 2);
    chk("seqA dis cnt0", int'(off_count0), 2);

    // Zero blank and off times: one-cycle BLANK and one-cycle OFF.
    set_cfg(0, 0, 0);
    enable = 1'b1;
    tick();
    chk_ch0("seqB blank", 1, 0, 0, 0);
    tick();
    chk_ch0("seqB on", 2, 0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      offtimer_en0 = 1'b1;
      tick();
      $display("seqB req %0d: s0=%0d ot0=%0d c0=%0d", r, state0, off_timer0, off_count0);
      chk($sformatf("seqB off%0d", r), int'(state0), 3);
      chk($sformatf("seqB cnt%0d", r), int'(off_count0), 3 + r);
      offtimer_en0 = 1'b0;
      tick();
      chk($sformatf("seqB blank%0d", r), int'(state0), 1);
      tick();
      chk($sformatf("seqB on%0d", r), int'(state0), 2);
    end
    chk("seqB ch1 on", int'(state1), 2);

    // Reset asserted mid-BLANK; phase changes during reset must not step on release.
    set_cfg(5, 5, 4);
    phase_ct = 8'h14;
    tick();
    chk_ch0("seqC blank", 1, 5, 0, 5);
    resetn = 1'b0;
    phase_ct = 8'h20;
    tick();
    $display("seqC reset: s0=%0d bt0=%0d c0=%0d c1=%0d", state0, blank_timer0, off_count0, off_count1);
    chk_ch0("seqC rst", 0, 0, 0, 0);
    chk_ch1("seqC rst", 0, 0, 0, 0);
    chk("seqC rst cnt0", int'(off_count0), 0);
    chk("seqC rst cnt1", int'(off_count1), 0);
    resetn = 1'b1; enable = 1'b0;
    tick();
    set_cfg(3, 5, 4);
    enable = 1'b1;
    tick();
    tick();
    chk_ch0("seqC nostep", 1, 2, 0, 4);

    // Counter saturation on the narrow instance.
    set_cfg(0, 0, 0);
    tick();
    tick();
    chk("sat on", int'(state0), 2);
    for (int r = 0; r < 20; r++) begin
      offtimer_en0 = 1'b1;
      tick();
      offtimer_en0 = 1'b0;
      $display("sat req %0d: c0=%0d c0_narrow=%0d", r, off_count0, s_cnt0);
      chk($sformatf("sat narrow%0d", r), int'(s_cnt0), (r + 1 > 15) ? 15 : r + 1);
      tick();
      tick();
    end
    chk("sat wide cnt0", int'(off_count0), 20);
    chk("sat narrow cnt1", int'(s_cnt1), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
